p4_router_egr_scheduler: RTL and testbench

P4_ROUTER_EGR_SCHEDULER -- requirements
Module: p4_router_egr_scheduler

---
 rtl/p4_router_pkg.sv | 20 ++
 rtl/p4_router_rr_arb.sv | 28 ++
 rtl/p4_router_egr_scheduler.sv | 144 ++++++++++++++
 tb/tb_p4_router_egr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared constants and types for the P4 router egress path.
// The scheduler and its arbiter import everything from here.
package p4_router_pkg;

  localparam int NUM_QUEUES_PER_EGR_PORT = 4;
  localparam int DQ_LATENCY              = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } sched_state_t;

  // Port/queue pair carried on the dequeue request and notification buses.
  typedef struct packed {
    logic [4:0] port;
    logic [1:0] queue;
  } dq_sel_t;

endpackage

// File: rtl/p4_router_rr_arb.sv
// Rotating-priority arbiter: the search starts one past 'last' and wraps.
// Produces a one-hot grant, its index and an any-grant flag.
module p4_router_rr_arb #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Walk from the farthest position to the nearest, so the nearest hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        gnt_idx = IW'((int'(last) + i) % N);
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/p4_router_egr_scheduler.sv
// Egress dequeue scheduler: round-robin across ports, strict priority across
// queues, with per-queue accounting of dequeues not yet notified.
module p4_router_egr_scheduler
  import p4_router_pkg::*;
#(
  parameter int NUM_EGR_PORTS   = 8,
  parameter int NUM_QUEUES      = NUM_QUEUES_PER_EGR_PORT,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PKT_CNT_WIDTH   = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              enable,
  input  logic [NUM_EGR_PORTS*NUM_QUEUES*PKT_CNT_WIDTH-1:0] q_pkt_cnt,
  input  logic [NUM_EGR_PORTS-1:0]                          port_ready,
  output logic                                              dq_req_valid,
  input  logic                                              dq_req_ready,
  output logic [4:0]                                        dq_req_port,
  output logic [1:0]                                        dq_req_queue,
  input  logic                                              dq_notif_valid,
  input  logic [4:0]                                        dq_notif_port,
  input  logic [1:0]                                        dq_notif_queue,
  output logic                                              sched_idle,
  output logic                                              notif_err
);

  localparam int PW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW  = PW + $clog2(NUM_QUEUES) + 1;
  localparam int PIW = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;

  sched_state_t state, state_nxt;

  logic [NUM_EGR_PORTS-1:0][NUM_QUEUES-1:0][PW-1:0] pending;
  logic [NUM_EGR_PORTS-1:0][NUM_QUEUES-1:0]         elig, inc, dec, err_hit;
  logic [NUM_EGR_PORTS-1:0][1:0]                    top_q;
  logic [NUM_EGR_PORTS-1:0]                         port_req, gnt;
  logic [PIW-1:0]                                   gnt_idx, rr_ptr;
  logic                                             gnt_vld;
  logic [1:0]                                       gnt_q;
  dq_sel_t                                          req_r;
  logic                                             hs, launch, notif_bad;

  assign hs     = dq_req_valid && dq_req_ready;
  assign launch = (state == ARB) && enable && gnt_vld;

  for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_port
    logic [TW-1:0] tot;
    logic [1:0]    q_sel;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
      localparam int IDX = p * NUM_QUEUES + q;

      // Packets still resident beyond those already asked for.
      assign elig[p][q] = q_pkt_cnt[IDX*PKT_CNT_WIDTH +: PKT_CNT_WIDTH]
                          > PKT_CNT_WIDTH'(pending[p][q]);

      assign inc[p][q] = hs && (req_r.port == 5'(p)) && (req_r.queue == 2'(q));
      assign dec[p][q] = dq_notif_valid && (dq_notif_port == 5'(p))
                         && (dq_notif_queue == 2'(q));
      assign err_hit[p][q] = dec[p][q] && !inc[p][q] && (pending[p][q] == '0);

      // A coincident issue and completion cancel; an underflow is swallowed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          pending[p][q] <= '0;
        else if (inc[p][q] && !dec[p][q])
          pending[p][q] <= pending[p][q] + PW'(1);
        else if (dec[p][q] && !inc[p][q] && (pending[p][q] != '0))
          pending[p][q] <= pending[p][q] - PW'(1);
      end
    end

    // Highest eligible queue index wins within the port.
    always_comb begin
      tot   = '0;
      q_sel = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        tot = tot + TW'(pending[p][q]);
        if (elig[p][q]) q_sel = 2'(q);
      end
    end

    assign top_q[p]    = q_sel;
    assign port_req[p] = port_ready[p] && (tot < TW'(MAX_OUTSTANDING)) && (|elig[p]);
  end

  p4_router_rr_arb #(.N(NUM_EGR_PORTS)) u_rr_arb (
    .req     (port_req),
    .last    (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_q = '0;
    for (int p = 0; p < NUM_EGR_PORTS; p++)
      if (gnt[p]) gnt_q = top_q[p];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; an issued request always completes before IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = ARB;
      ARB:     if (!enable) state_nxt = IDLE;
               else if (gnt_vld) state_nxt = REQ;
      REQ:     if (dq_req_ready) state_nxt = enable ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dq_req_valid = (state == REQ);
    sched_idle   = (state == IDLE) && (pending == '0);
  end

  assign notif_bad = (dq_notif_valid && ((32'(dq_notif_port) >= 32'(NUM_EGR_PORTS))
                                      || (32'(dq_notif_queue) >= 32'(NUM_QUEUES))))
                     || (|err_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r     <= '0;
      rr_ptr    <= PIW'(NUM_EGR_PORTS - 1);
      notif_err <= 1'b0;
    end else begin
      if (launch) req_r <= '{port: 5'(gnt_idx), queue: gnt_q};
      if (hs)     rr_ptr <= PIW'(req_r.port);
      if (notif_bad) notif_err <= 1'b1;
    end
  end

  assign dq_req_port  = req_r.port;
  assign dq_req_queue = req_r.queue;

endmodule

// File: tb/tb_p4_router_egr_scheduler.sv
// Directed bench for the egress scheduler with a per-cycle reference model
// of pending counts, round-robin choice and the sticky error flag.
module tb_p4_router_egr_scheduler;
  import p4_router_pkg::*;

  localparam int NP = 8;
  localparam int NQ = 4;
  localparam int MO = 4;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst_n, enable;
  logic [NP*NQ*CW-1:0] q_pkt_cnt;
  logic [NP-1:0]    port_ready;
  logic             dq_req_valid, dq_req_ready;
  logic [4:0]       dq_req_port;
  logic [1:0]       dq_req_queue;
  logic             dq_notif_valid;
  logic [4:0]       dq_notif_port;
  logic [1:0]       dq_notif_queue;
  logic             sched_idle, notif_err;

  always #5 clk = ~clk;

  p4_router_egr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .q_pkt_cnt(q_pkt_cnt),
    .port_ready(port_ready), .dq_req_valid(dq_req_valid), .dq_req_ready(dq_req_ready),
    .dq_req_port(dq_req_port), .dq_req_queue(dq_req_queue),
    .dq_notif_valid(dq_notif_valid), .dq_notif_port(dq_notif_port),
    .dq_notif_queue(dq_notif_queue), .sched_idle(sched_idle), .notif_err(notif_err)
  );

  int n_checks = 0, n_errs = 0, cyc = 0;
  int m_pend[NP][NQ];
  int m_rr;
  bit m_err;
  bit prev_valid, prev_ready, prev_en, exp_vld, auto_notif;
  int prev_port, prev_queue, exp_p, exp_q;
  int log_p[$], log_q[$];
  int due_c[$], due_p[$], due_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int cnt(input int p, input int q);
    return int'(q_pkt_cnt[(p*NQ+q)*CW +: CW]);
  endfunction

  task automatic set_cnt(input int p, input int q, input int v);
    q_pkt_cnt[(p*NQ+q)*CW +: CW] = CW'(v);
  endtask

  // Next port after the last served one that is ready, has headroom and holds
  // an unrequested packet; within it, the highest such queue.
  function automatic bit model_pick(output int pp, output int qq);
    pp = 0; qq = 0;
    for (int k = 1; k <= NP; k++) begin
      int p = (m_rr + k) % NP;
      int tot = 0;
      for (int q = 0; q < NQ; q++) tot += m_pend[p][q];
      if (port_ready[p] && tot < MO)
        for (int q = NQ-1; q >= 0; q--)
          if (cnt(p, q) > m_pend[p][q]) begin pp = p; qq = q; return 1'b1; end
    end
    return 1'b0;
  endfunction

  task automatic cmp_cycle();
    int pp, qq, tot;
    bit hs, same;
    if (!rst_n) begin
      foreach (m_pend[p, q]) m_pend[p][q] = 0;
      m_rr = NP-1; m_err = 0;
      prev_valid = 0; prev_ready = 0; prev_en = 0; exp_vld = 0;
      return;
    end
    chk("notif_err", notif_err, m_err);
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", dq_req_valid, 1);
      chk("hold_port", dq_req_port, prev_port);
      chk("hold_queue", dq_req_queue, prev_queue);
    end else if (dq_req_valid && !prev_valid) begin
      chk("arb_found", exp_vld && prev_en, 1);
      chk("arb_port", dq_req_port, exp_p);
      chk("arb_queue", dq_req_queue, exp_q);
    end
    if (sched_idle) begin
      tot = 0;
      foreach (m_pend[p, q]) tot += m_pend[p][q];
      chk("idle_pending", tot, 0);
      chk("idle_novalid", dq_req_valid, 0);
    end
    exp_vld = model_pick(pp, qq);
    exp_p = pp; exp_q = qq; prev_en = enable;
    hs   = dq_req_valid && dq_req_ready;
    same = hs && dq_notif_valid && dq_notif_port == dq_req_port && dq_notif_queue == dq_req_queue;
    if (hs) begin
      if (!same) m_pend[dq_req_port][dq_req_queue]++;
      m_rr = dq_req_port;
      log_p.push_back(dq_req_port); log_q.push_back(dq_req_queue);
      if (auto_notif) begin
        due_c.push_back(cyc + DQ_LATENCY); due_p.push_back(dq_req_port); due_q.push_back(dq_req_queue);
      end
    end
    if (dq_notif_valid) begin
      if (dq_notif_port >= NP) m_err = 1;
      else if (!same) begin
        if (m_pend[dq_notif_port][dq_notif_queue] == 0) m_err = 1;
        else m_pend[dq_notif_port][dq_notif_queue]--;
      end
    end
    prev_valid = dq_req_valid; prev_ready = dq_req_ready;
    prev_port = dq_req_port; prev_queue = dq_req_queue;
  endtask

  // One clock: compare at the falling edge, then drive after the rising edge.
  // Auto notifications also retire the packet from the queue count.
  task automatic tick();
    int p, q;
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
    cyc++;
    dq_notif_valid = 1'b0;
    if (due_c.size() > 0 && due_c[0] <= cyc) begin
      void'(due_c.pop_front());
      p = due_p.pop_front(); q = due_q.pop_front();
      dq_notif_valid = 1'b1; dq_notif_port = 5'(p); dq_notif_queue = 2'(q);
      if (cnt(p, q) > 0) set_cnt(p, q, cnt(p, q) - 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; dq_req_ready = 1'b1; port_ready = '1; q_pkt_cnt = '0;
    dq_notif_valid = 1'b0; dq_notif_port = '0; dq_notif_queue = '0; auto_notif = 1'b0;
    due_c.delete(); due_p.delete(); due_q.delete(); log_p.delete(); log_q.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dq_req_valid && n < 20) begin tick(); n++; end
    chk(name, dq_req_valid, 1);
  endtask

  task automatic wait_log(input int want, input int budget, input string name);
    int n = 0;
    while (log_p.size() < want && n < budget) begin tick(); n++; end
    chk(name, log_p.size() >= want, 1);
  endtask

  task automatic manual_notif(input int p, input int q);
    dq_notif_valid = 1'b1; dq_notif_port = 5'(p); dq_notif_queue = 2'(q);
  endtask

  initial begin
    int s2_ports[6];
    int n;
    s2_ports = '{0, 1, 5, 0, 1, 5};

    // Reset values
    do_reset();
    chk("rst_valid", dq_req_valid, 0);
    chk("rst_port", dq_req_port, 0);
    chk("rst_queue", dq_req_queue, 0);
    chk("rst_idle", sched_idle, 1);
    chk("rst_err", notif_err, 0);

    // Port 2 queues 0 and 3: priority gives queue 3 first
    set_cnt(2, 0, 1); set_cnt(2, 3, 1);
    auto_notif = 1'b1; enable = 1'b1;
    repeat (30) tick();
    chk("s1_count", log_p.size(), 2);
    if (log_p.size() >= 2) begin
      chk("s1_first_port", log_p[0], 2);  chk("s1_first_queue", log_q[0], 3);
      chk("s1_second_port", log_p[1], 2); chk("s1_second_queue", log_q[1], 0);
    end
    enable = 1'b0;
    repeat (3) tick();
    chk("s1_idle", sched_idle, 1);

    // Round robin over ports 0, 1, 5
    do_reset();
    set_cnt(0, 0, 10); set_cnt(1, 0, 10); set_cnt(5, 0, 10);
    auto_notif = 1'b1; enable = 1'b1;
    wait_log(6, 100, "s2_timeout");
    if (log_p.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        chk("s2_port", log_p[i], s2_ports[i]);
        chk("s2_queue", log_q[i], 0);
      end

    // Outstanding limit with notifications withheld
    do_reset();
    set_cnt(0, 1, 100);
    enable = 1'b1;
    repeat (30) tick();
    chk("s3_stall_count", log_p.size(), 4);
    n = 0;
    foreach (log_p[i]) if (log_p[i] != 0 || log_q[i] != 1) n++;
    chk("s3_wrong_pairs", n, 0);
    manual_notif(0, 1); set_cnt(0, 1, 99);
    repeat (20) tick();
    chk("s3_resume_count", log_p.size(), 5);

    // Backpressure with enable dropped mid-request
    do_reset();
    set_cnt(4, 2, 1); dq_req_ready = 1'b0; auto_notif = 1'b1; enable = 1'b1;
    wait_valid("s4_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable = 1'b0;
      tick();
    end
    chk("s4_held_valid", dq_req_valid, 1);
    chk("s4_held_port", dq_req_port, 4);
    chk("s4_held_queue", dq_req_queue, 2);
    dq_req_ready = 1'b1;
    tick();
    chk("s4_done_valid", dq_req_valid, 0);
    chk("s4_done_count", log_p.size(), 1);
    chk("s4_busy_idle", sched_idle, 0);
    n = 0;
    while (!sched_idle && n < 10) begin tick(); n++; end
    chk("s4_final_idle", sched_idle, 1);

    // Notification for an out-of-range port
    do_reset();
    manual_notif(9, 0);
    tick();
    chk("s5_range_err", notif_err, 1);

    // Notification with nothing pending; error is sticky
    do_reset();
    chk("s5_err_cleared", notif_err, 0);
    manual_notif(3, 0);
    tick();
    chk("s5_underflow_err", notif_err, 1);
    repeat (3) tick();
    chk("s5_sticky_err", notif_err, 1);
    chk("s5_counts_zero", sched_idle, 1);

    // Issue and notification on (1,2) in the same cycle
    do_reset();
    set_cnt(1, 2, 2); enable = 1'b1;
    wait_log(1, 20, "s6_first_timeout");
    dq_req_ready = 1'b0;
    wait_valid("s6_valid_timeout");
    enable = 1'b0; dq_req_ready = 1'b1;
    manual_notif(1, 2); set_cnt(1, 2, 1);
    tick();
    chk("s6_issue_count", log_p.size(), 2);
    chk("s6_pending_left", sched_idle, 0);
    manual_notif(1, 2); set_cnt(1, 2, 0);
    tick();
    chk("s6_drained_idle", sched_idle, 1);
    chk("s6_no_err", notif_err, 0);

    // Reset asserted mid-request
    do_reset();
    set_cnt(6, 1, 1); dq_req_ready = 1'b0; enable = 1'b1;
    wait_valid("s7_valid_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("s7_valid", dq_req_valid, 0);
    chk("s7_port", dq_req_port, 0);
    chk("s7_queue", dq_req_queue, 0);
    chk("s7_idle", sched_idle, 1);
    chk("s7_err", notif_err, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
